// File: rtl/uart_rx_if.sv
// Serial-side bundle of the UART receiver: oversampling strobe and line in,
// received byte plus completion/error strobes out.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receive engine: 16x oversampled, mid-bit sampling, registered done/error pulses.
// Latency: done one clk after the s_tick that ends the stop period; no back-pressure, dout holds until next frame.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX) + 1;
  localparam int NW   = $clog2(DBIT) + 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Edge detection is tick-independent; a coincident tick is deliberately not counted.
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == S_HALF) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP) begin
            // A low stop bit still delivers the byte; the low line then reads as the next start.
            dout_d  = b_q;
            done_d  = 1'b1;
            ferr_d  = ~rx_s_q;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of directed frames, randomized frames against a frame-level model,
// and hand sequences for reset abort, reset release with low line, and stop-length timing.
module tb_uart_rx;

  localparam int DIV = 5;
  localparam int OVS = 16;
  localparam int BIT = OVS * DIV;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s_tick = 1'b0;
  logic rx_drv = 1'b1;
  logic sel32  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.DBIT(8)) bus16 ();
  uart_rx_if #(.DBIT(8)) bus32 ();

  assign bus16.s_tick = s_tick;
  assign bus16.rx     = rx_drv;
  assign bus32.s_tick = s_tick;
  assign bus32.rx     = sel32 ? rx_drv : 1'b1;

  uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut16 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus16)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32), .OVS(16)) dut32 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus32)
  );

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } frm_t;

  frm_t got_q[$];
  frm_t exp_q[$];

  longint     t16 = 0;
  longint     t32 = 0;
  logic [7:0] d32 = '0;
  logic       f32 = 1'b0;
  int         n32 = 0;

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    int         gap;
    bit         glitch;
    bit         has_out;
    logic [7:0] exp_d;
    bit         exp_fe;
  } vec_t;

  vec_t vt[8];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c = (c + 1) % DIV;
      s_tick = (c == 0);
    end
  end

  always @(negedge clk) begin
    if (bus16.rx_done_tick) begin
      got_q.push_back('{bus16.dout, bus16.frame_err});
      t16 = cyc;
    end
    if (bus16.frame_err && !bus16.rx_done_tick) begin
      checks++;
      errors++;
      $display("FAIL ferr_orphan: frame_err=1 with rx_done_tick=0 at cycle %0d", cyc);
    end
    if (bus32.rx_done_tick) begin
      t32 = cyc;
      d32 = bus32.dout;
      f32 = bus32.frame_err;
      n32++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int nstop, input int gap);
    rx_drv = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      wait_cyc(BIT);
    end
    if (stop_ok) begin
      rx_drv = 1'b1;
      wait_cyc(nstop * BIT);
    end else begin
      // Low long enough to be sampled mid-bit, high again before the spurious start is qualified.
      rx_drv = 1'b0;
      wait_cyc(3 * BIT / 4);
      rx_drv = 1'b1;
      wait_cyc(BIT / 4);
    end
    rx_drv = 1'b1;
    if (gap > 0) wait_cyc(gap * BIT);
  endtask

  task automatic compare_queue(input string tag);
    frm_t g;
    frm_t e;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_dout"}, 64'(g.d), 64'(e.d));
      check({tag, "_ferr"}, 64'(g.fe), 64'(e.fe));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    logic [7:0] rd;
    bit         rok;
    int         rgap;
    logic [7:0] lowb;

    vt[0] = '{8'hA5, 1'b1, 2, 1'b0, 1'b1, 8'hA5, 1'b0};
    vt[1] = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[3] = '{8'h55, 1'b1, 2, 1'b0, 1'b1, 8'h55, 1'b0};
    vt[4] = '{8'h00, 1'b1, 2, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[5] = '{8'h3C, 1'b1, 2, 1'b0, 1'b1, 8'h3C, 1'b0};
    vt[6] = '{8'h81, 1'b0, 2, 1'b0, 1'b1, 8'h81, 1'b1};
    vt[7] = '{8'hE7, 1'b1, 2, 1'b0, 1'b1, 8'hE7, 1'b0};

    // Reset state
    wait_cyc(3);
    @(negedge clk);
    check("reset_dout", 64'(bus16.dout), 64'h0);
    check("reset_done", 64'(bus16.rx_done_tick), 64'h0);
    check("reset_ferr", 64'(bus16.frame_err), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(2 * BIT);

    // Directed table
    for (int v = 0; v < 8; v++) begin
      if (vt[v].glitch) begin
        rx_drv = 1'b0;
        wait_cyc(4 * DIV);
        rx_drv = 1'b1;
        wait_cyc(vt[v].gap * BIT);
      end else begin
        send_frame(vt[v].d, vt[v].stop_ok, 1, vt[v].gap);
      end
      if (vt[v].has_out) exp_q.push_back('{vt[v].exp_d, vt[v].exp_fe});
    end
    wait_cyc(BIT);
    compare_queue("table");

    // Stop length: both receivers see the same two-stop-bit frame
    sel32 = 1'b1;
    n32 = 0;
    send_frame(8'h96, 1'b1, 2, 2);
    sel32 = 1'b0;
    exp_q.push_back('{8'h96, 1'b0});
    compare_queue("stop16");
    check("stop32_count", 64'(n32), 64'd1);
    check("stop32_dout", 64'(d32), 64'h96);
    check("stop32_ferr", 64'(f32), 64'h0);
    check("stop32_delay", 64'(t32 - t16), 64'(16 * DIV));

    // Randomized frames against the frame-level model
    for (int k = 0; k < 30; k++) begin
      rd   = 8'($urandom_range(0, 255));
      rok  = ($urandom_range(0, 4) != 0);
      rgap = rok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(rd, rok, 1, rgap);
      exp_q.push_back('{rd, ~rok});
    end
    wait_cyc(2 * BIT);
    compare_queue("random");

    // Reset during data bit 3 of 0xC3
    rx_drv = 1'b0;
    wait_cyc(BIT);
    lowb = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      rx_drv = lowb[i];
      wait_cyc(BIT);
    end
    rx_drv = lowb[3];
    wait_cyc(BIT / 2);
    rst_n = 1'b0;
    wait_cyc(3);
    @(negedge clk);
    check("midreset_dout", 64'(bus16.dout), 64'h0);
    check("midreset_done", 64'(bus16.rx_done_tick), 64'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rx_drv = 1'b1;
    wait_cyc(12 * BIT);
    check("midreset_no_pulse", 64'(got_q.size()), 64'd0);
    check("midreset_dout_hold", 64'(bus16.dout), 64'h0);
    got_q.delete();
    send_frame(8'h7E, 1'b1, 1, 2);
    exp_q.push_back('{8'h7E, 1'b0});
    compare_queue("after_reset");

    // Line already low at reset release acts as the start edge
    rx_drv = 1'b0;
    rst_n  = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(BIT);
    lowb = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      rx_drv = lowb[i];
      wait_cyc(BIT);
    end
    rx_drv = 1'b1;
    wait_cyc(3 * BIT);
    exp_q.push_back('{8'h5A, 1'b0});
    compare_queue("low_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine for the UART module. It deserialises an 8N1 serial stream on `rx` using the 16x-oversampling `s_tick` strobe from the baud-rate generator. Each received byte is presented on `dout` with a one-cycle `rx_done_tick`. It is the receive-side counterpart to the baud generator and sits between the pin synchroniser boundary and the RX FIFO / interface logic.

## Interface
- `DBIT`, 8: number of data bits per frame, LSB first.
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `OVS`, 16: oversampling ratio, i.e. `s_tick` per bit period; must be a power of two, at least 8.

Ports:
- `clk`  in  1  system clock (100 MHz nominal).
- `reset`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-`clk`-wide strobe at OVS × baud, from `br_generator`.
- `rx`  in  1  serial input, asynchronous to `clk`; idle high.
- `dout`  out  DBIT  last received data byte; holds until the next frame completes.
- `rx_done_tick`  out  1  one-`clk` pulse when a frame completes.
- `frame_err`  out  1  one-`clk` pulse, coincident with `rx_done_tick`, when the stop bit sampled low.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1). All FSM decisions use the synchronised value `rx_s`.
- Registers:
  - tick counter `s`, width log2(max(OVS, SB_TICK)) + 1
  - bit counter `n`, width log2(DBIT) + 1
  - shift register `b`, DBIT bits
  - state
- All counters advance only on cycles where `s_tick` = 1.
- FSM states:
  - IDLE: when `rx_s` = 0, go to START and clear `s`. `s_tick` is not required for this transition.
  - START: on tick, if `s` = OVS/2−1:
    - `rx_s` = 0: go to DATA, clear `s` and `n`.
    - `rx_s` = 1: glitch; return to IDLE, no output.
    - Otherwise increment `s`.
  - DATA: on tick, if `s` = OVS−1: clear `s` and shift `b` ← {`rx_s`, `b`[DBIT−1:1]}. If `n` = DBIT−1, go to STOP; otherwise increment `n`. Otherwise increment `s`.
  - STOP: on tick, if `s` = SB_TICK−1:
    - Load `dout` ← `b`.
    - Pulse `rx_done_tick`.
    - Pulse `frame_err` if `rx_s` = 0.
    - Go to IDLE.
    - Otherwise increment `s`.
- Data bits are sampled at mid-bit: OVS/2 ticks after the falling edge, then every OVS ticks.
- Framing error: the byte is still delivered. When the stop bit samples low, the FSM returns to IDLE and a new frame begins immediately, because `rx_s` is still 0.
- Reset values:
  - state = IDLE
  - `s`, `n`, `b`, `dout` = 0
  - `rx_done_tick` and `frame_err` = 0
  - synchroniser flops = 1
- Reset assertion mid-frame aborts the frame without a done pulse. After release the FSM waits in IDLE for a falling edge.
- A low `rx` held through reset release counts as a start edge 2 cycles after release.
- `s_tick` arriving in the same cycle as the IDLE→START transition is not counted.

## Timing
- Synchroniser latency: 2 `clk` cycles from the `rx` edge to `rx_s`.
- `rx_done_tick` and `frame_err` are registered. They assert on the `clk` edge after the `s_tick` that completes STOP, and last exactly 1 cycle.
- `dout` changes on the same edge that `rx_done_tick` rises.
- Frame duration: OVS/2 + DBIT·OVS + SB_TICK ticks after the start edge (152 ticks with defaults), ±1 tick of edge-alignment uncertainty.
- Receiver tolerates ±1/OVS bit of phase error plus about 3% baud mismatch over a frame.
- No back-pressure: a downstream consumer must capture `dout` before the next `rx_done_tick`, at least 152 ticks later.

## Test plan
Bench setup for all cases:
- 100 MHz clock.
- `s_tick` from `br_generator` at 19200 × 16, i.e. one tick per 326 cycles.
- Bit period for `rx` = 16 × 326 cycles.

Scenarios:
- Single byte: drive 0xA5 as 8N1, LSB first → exactly one `rx_done_tick`, `dout` = 0xA5, `frame_err` = 0, FSM back in IDLE.
- Back-to-back: bytes 0x00, 0xFF, 0x55 with no idle gap between stop and next start → three done pulses, `dout` sequence 0x00, 0xFF, 0x55, no `frame_err`.
- Glitch rejection: pulse `rx` low for 4 ticks (4 × 326 cycles), then high → no `rx_done_tick`, FSM returns to IDLE. A following valid 0x3C is then received correctly.
- Framing error: send 0x81 with the stop bit driven low, then `rx` high → `rx_done_tick` = 1 and `frame_err` = 1 in the same cycle, `dout` = 0x81.
- Reset mid-frame: assert `reset` = 0 during data bit 3 of 0xC3 → `dout` = 0 and no pulses. After release, a fresh 0x7E is received as 0x7E.
- Stop length: `SB_TICK` = 32 with two stop bits on `rx` → 0x96 received. `rx_done_tick` occurs 16 ticks later than with `SB_TICK` = 16.
